bpu_resolve_controller: RTL

- Sequences branch-prediction resolution between the BPU and the ground-truth feedback unit.
- Tracks in-flight predictions in a small in-order queue and matches each against its feedback entry.
- Emits BPU training updates, and on a mispredict emits a fetch redirect, a flush and a recovery stall.
- Sits between the BPU output, the ground-truth feedback path and the IFU PC-select logic; it also keeps resolution statistics.

---
 rtl/bpu_resolve_controller.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/bpu_resolve_controller.sv
// Branch-prediction resolution controller: in-order pending queue,
// BPU training updates, mispredict redirect/flush/recover sequencing.
module bpu_resolve_controller #(
  parameter int PEND_DEPTH  = 4,
  parameter int RECOVER_CYC = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ctrl_en,
  input  logic                 pred_valid,
  output logic                 pred_ready,
  input  logic [31:0]          pred_pc,
  input  logic                 pred_taken,
  input  logic [31:0]          pred_target,
  input  logic                 fb_valid,
  input  logic                 fb_is_branch,
  input  logic                 fb_taken,
  input  logic [31:0]          fb_target,
  output logic                 upd_valid,
  output logic [31:0]          upd_pc,
  output logic                 upd_is_branch,
  output logic                 upd_taken,
  output logic [31:0]          upd_target,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 flush,
  output logic                 fetch_stall,
  output logic                 orphan_err,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  localparam int PW  = $clog2(PEND_DEPTH);
  localparam int RCW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_FLUSH   = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [RCW-1:0] rc_q;
  logic [PW-1:0]  wr_q, rd_q;
  logic [PW:0]    cnt_q;

  logic [31:0] pc_mem  [PEND_DEPTH];
  logic        tk_mem  [PEND_DEPTH];
  logic [31:0] tgt_mem [PEND_DEPTH];

  logic        upd_valid_q, upd_is_branch_q, upd_taken_q;
  logic [31:0] upd_pc_q, upd_target_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;
  logic        orphan_q;
  logic [CNT_WIDTH-1:0] branch_cnt_q, mispred_cnt_q;

  logic        empty, full, in_run, push, pop, mis, kill;
  logic [31:0] head_pc, head_tgt, corr_pc;
  logic        head_tk;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(PEND_DEPTH));
  assign in_run  = (state_q == S_RUN);
  assign head_pc  = pc_mem[rd_q];
  assign head_tk  = tk_mem[rd_q];
  assign head_tgt = tgt_mem[rd_q];

  assign pred_ready = in_run && ctrl_en && !full;
  assign push = pred_valid && pred_ready;
  assign pop  = in_run && fb_valid && !empty;

  always_comb begin
    mis = head_tk;
    if (fb_is_branch)
      mis = (head_tk != fb_taken) ||
            (fb_taken && (head_tgt != fb_target));
    corr_pc = (fb_is_branch && fb_taken) ?
              fb_target : head_pc + 32'd4;
  end

  assign kill = pop && mis;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (ctrl_en) state_d = S_RUN;
      S_RUN:     if (kill) state_d = S_FLUSH;
      S_FLUSH:   state_d = S_RECOVER;
      S_RECOVER: if (rc_q == '0)
                   state_d = ctrl_en ? S_RUN : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FLUSH)
        rc_q <= RCW'(RECOVER_CYC - 1);
      else if (state_q == S_RECOVER && rc_q != '0)
        rc_q <= rc_q - RCW'(1);
    end
  end

  // A mispredict pop discards any same-cycle push along with the queue
  always_ff @(posedge clk) begin
    if (rst || kill || state_q == S_FLUSH) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]  <= pred_pc;
      tk_mem[wr_q]  <= pred_taken;
      tgt_mem[wr_q] <= pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_is_branch_q  <= 1'b0;
      upd_taken_q      <= 1'b0;
      upd_target_q     <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      orphan_q         <= 1'b0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      upd_valid_q      <= pop && (fb_is_branch || head_tk);
      redirect_valid_q <= kill;
      if (pop) begin
        upd_pc_q        <= head_pc;
        upd_is_branch_q <= fb_is_branch;
        upd_taken_q     <= fb_taken;
        upd_target_q    <= fb_target;
      end
      if (kill)
        redirect_pc_q <= corr_pc;
      if (in_run && fb_valid && empty)
        orphan_q <= 1'b1;
      if (pop && fb_is_branch && !(&branch_cnt_q))
        branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
      if (kill && !(&mispred_cnt_q))
        mispred_cnt_q <= mispred_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_is_branch  = upd_is_branch_q;
  assign upd_taken      = upd_taken_q;
  assign upd_target     = upd_target_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = (state_q == S_FLUSH);
  assign fetch_stall    = (state_q == S_FLUSH) ||
                          (state_q == S_RECOVER);
  assign orphan_err     = orphan_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule
